// File: rtl/mdr_op_sequencer.sv
// mdr_op_sequencer: one-at-a-time MDR front end that clears, starts and collects exactly one engine per request.
// Define MDR_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT cycles (err 11).
module mdr_op_sequencer #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [DW-1:0]   req_a,
    input  logic [DW-1:0]   req_b,
    output logic [DW-1:0]   eng_a,
    output logic [DW-1:0]   eng_b,
    output logic            eng_sync_rst,
    output logic [2:0]      eng_start,
    input  logic [2:0]      eng_done,
    input  logic [2*DW-1:0] mul_res,
    input  logic [2*DW-1:0] div_res,
    input  logic [2*DW-1:0] sqrt_res,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_data,
    output logic [1:0]      rsp_err,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, ABORT, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] op;
    logic accept, legal, done_sel, expire;
    logic [2*DW-1:0] res_sel;
    assign accept = req_valid && state == IDLE;
    assign legal = req_op != 2'b11 && !(req_op == 2'b01 && req_b == '0);
    // Completion and result both follow the latched op, never the live request
    assign done_sel = op == 2'd0 ? eng_done[0] : op == 2'd1 ? eng_done[1] : eng_done[2];
    assign res_sel = op == 2'd0 ? mul_res : op == 2'd1 ? div_res : sqrt_res;
`ifdef MDR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= state == WAIT ? cnt + 1'b1 : '0;
    assign expire = state == WAIT && cnt == CW'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (legal ? CLEAR : RESP) : IDLE;
            CLEAR:   state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = done_sel ? RESP : expire ? ABORT : WAIT;
            ABORT:   state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready    = state == IDLE;
        busy         = state != IDLE;
        rsp_valid    = state == RESP;
        eng_sync_rst = state == CLEAR || state == ABORT;
        eng_start    = state == START ? {op == 2'd2, op == 2'd1, op == 2'd0} : 3'b000;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op       <= 2'b00;
            eng_a    <= '0;
            eng_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 2'b00;
        end else if (accept) begin
            op       <= req_op;
            eng_a    <= req_a;
            eng_b    <= req_b;
            rsp_data <= req_op == 2'b11 || legal ? '0 : '1;
            rsp_err  <= req_op == 2'b11 ? 2'b01 : legal ? 2'b00 : 2'b10;
        end else if (state == WAIT && (done_sel || expire)) begin
            rsp_data <= done_sel ? res_sel : '0;
            rsp_err  <= done_sel ? 2'b00 : 2'b11;
        end
endmodule

// File: tb/tb_mdr_op_sequencer.sv
// tb_mdr_op_sequencer: randomized transactions against an arithmetic model of the MDR engines.
module tb_mdr_op_sequencer;
    localparam int DW = 16;
    localparam int TIMEOUT = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, eng_sync_rst, busy;
    logic [1:0] req_op = 2'b00, rsp_err;
    logic [DW-1:0] req_a = '0, req_b = '0, eng_a, eng_b;
    logic [2:0] eng_start, eng_done = 3'b000;
    logic [2*DW-1:0] mul_res = '0, div_res = '0, sqrt_res = '0, rsp_data;
    int n_cmp = 0, n_err = 0;
    mdr_op_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .eng_a(eng_a), .eng_b(eng_b),
        .eng_sync_rst(eng_sync_rst), .eng_start(eng_start), .eng_done(eng_done),
        .mul_res(mul_res), .div_res(div_res), .sqrt_res(sqrt_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // What a correct engine returns: signed product, {rem,quot}, {rem,root}
    function automatic logic [31:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r = 0;
        case (op)
            2'd0: return 32'(sa * sb);
            2'd1: return {a % b, a / b};
            2'd2: begin
                while ((r + 1) * (r + 1) <= int'(a)) r++;
                return {16'(int'(a) - r * r), 16'(r)};
            end
            default: return 32'd0;
        endcase
    endfunction
    task automatic check_reset_vals();
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_err", rsp_err, 0);
        check("rst_start", eng_start, 0);
        check("rst_srst", eng_sync_rst, 0);
        check("rst_ea", eng_a, 0);
        check("rst_eb", eng_b, 0);
    endtask
    // Called at a negedge in IDLE; returns at a negedge in IDLE
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int done_dly, input int bp);
        logic [31:0] exp_d;
        logic [1:0] exp_e;
        logic [2:0] sel;
        bit legal, timed_out;
        legal = op != 2'd3 && !(op == 2'd1 && b == 16'd0);
        sel = 3'b001 << op;
        exp_d = op == 2'd3 ? 32'd0 : legal ? model(op, a, b) : 32'hFFFF_FFFF;
        exp_e = op == 2'd3 ? 2'd1 : legal ? 2'd0 : 2'd2;
        timed_out = 0;
        check("idle_ready", req_ready, 1);
        req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = 0;
        @(negedge clk);
        req_valid = 1'($urandom); req_op = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        if (legal) begin
            check("clear_srst", eng_sync_rst, 1);
            check("clear_start", eng_start, 0);
            check("eng_a", eng_a, a);
            check("eng_b", eng_b, b);
            check("clear_ready", req_ready, 0);
            eng_done = 3'($urandom);
            @(negedge clk);
            check("start_onehot", eng_start, sel);
            check("start_srst", eng_sync_rst, 0);
            eng_done = 3'($urandom);
            @(negedge clk);
            for (int k = 0; ; k++) begin
`ifdef MDR_TIMEOUT_EN
                if (k == TIMEOUT) begin
                    timed_out = 1;
                    break;
                end
`endif
                check("wait_valid", rsp_valid, 0);
                check("wait_start", eng_start | 3'(eng_sync_rst), 0);
                mul_res = 32'($urandom); div_res = 32'($urandom); sqrt_res = 32'($urandom);
                if (k == done_dly) begin
                    eng_done = sel | 3'($urandom);
                    if (sel[0]) mul_res = exp_d;
                    if (sel[1]) div_res = exp_d;
                    if (sel[2]) sqrt_res = exp_d;
                    break;
                end
                eng_done = 3'($urandom) & ~sel;
                @(negedge clk);
            end
            if (timed_out) begin
                check("abort_srst", eng_sync_rst, 1);
                check("abort_valid", rsp_valid, 0);
                eng_done = sel;
                exp_d = 32'd0;
                exp_e = 2'd3;
            end
            @(negedge clk);
        end
        for (int i = 0; i <= bp; i++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, exp_d);
            check("rsp_err", rsp_err, exp_e);
            check("rsp_ready_low", req_ready, 0);
            check("rsp_quiet", {eng_start, eng_sync_rst}, 0);
            eng_done = 3'($urandom);
            mul_res = 32'($urandom); div_res = 32'($urandom); sqrt_res = 32'($urandom);
            req_valid = 1;
            rsp_ready = i == bp;
            @(negedge clk);
        end
        req_valid = 0; rsp_ready = 0; eng_done = 0;
        check("back_idle", {req_ready, busy, rsp_valid}, 3'b100);
    endtask
    initial begin
        #2 check_reset_vals();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(2'd0, 16'h0003, 16'hFFFB, 3, 0);
        run_op(2'd1, 16'd100, 16'd7, 2, 0);
        run_op(2'd1, 16'd55, 16'd0, 0, 1);
        run_op(2'd3, 16'h1234, 16'h5678, 0, 0);
        run_op(2'd2, 16'd1000, 16'd0, 1, 10);
        req_valid = 1; req_op = 2'd0; req_a = 16'd9; req_b = 16'd9;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(2'd0, 16'd7, 16'd6, 0, 0);
        for (int n = 0; n < 60; n++) begin
            logic [15:0] rb;
            rb = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom);
            run_op(2'($urandom), 16'($urandom), rb, $urandom_range(0, 5), $urandom_range(0, 3));
        end
`ifdef MDR_TIMEOUT_EN
        run_op(2'd0, 16'd5, 16'd5, TIMEOUT, 0);
        run_op(2'd2, 16'd81, 16'd0, TIMEOUT - 1, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
